// File: rtl/muldiv_hilo_unit.sv
// muldiv_hilo_unit: sequential 32-iteration multiply/divide unit that owns the
// architectural HI/LO registers.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | waiting for start; MTHI/MTLO write HI/LO directly here
//   RUN   | one shift-add / restoring-divide iteration per clock, 32 total
//   FIXUP | sign correction, HI/LO write, done pulse, back to IDLE
module muldiv_hilo_unit #(
    parameter int          WIDTH      = 32,
    parameter logic [31:0] HILO_RESET = 32'h0000_0000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [5:0]       functcode,
    input  logic [WIDTH-1:0] rs_content,
    input  logic [WIDTH-1:0] rt_content,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] FIXUP = 2'd2;

    localparam logic [5:0] F_MTHI  = 6'h11;
    localparam logic [5:0] F_MTLO  = 6'h13;
    localparam logic [5:0] F_MULT  = 6'h18;
    localparam logic [5:0] F_MULTU = 6'h19;
    localparam logic [5:0] F_DIV   = 6'h1a;
    localparam logic [5:0] F_DIVU  = 6'h1b;

    logic [1:0]  state;
    logic [4:0]  count;
    logic [63:0] acc;       // mul: {partial product, multiplier}; div: {remainder, dividend/quotient}
    logic [31:0] opnd;      // mul: multiplicand magnitude; div: divisor magnitude
    logic [31:0] raw_rs;    // unmodified dividend, returned in HI on divide-by-zero
    logic        op_div;
    logic        res_neg;
    logic        rem_neg;
    logic        div_zero;
    logic [31:0] hi_q;
    logic [31:0] lo_q;
    logic        done_q;

    logic        is_signed;
    logic [31:0] mag_rs;
    logic [31:0] mag_rt;
    logic [32:0] mul_sum;
    logic [63:0] mul_next;
    logic [32:0] div_trial;
    logic        div_ge;
    logic [31:0] div_rem;
    logic [63:0] div_next;
    logic [63:0] prod_fix;
    logic [31:0] quot_fix;
    logic [31:0] rem_fix;

    // Operand magnitudes for signed ops, taken at the accepting edge.
    always_comb begin
        is_signed = (functcode == F_MULT) || (functcode == F_DIV);
        mag_rs    = (is_signed && rs_content[31]) ? (32'd0 - rs_content) : rs_content;
        mag_rt    = (is_signed && rt_content[31]) ? (32'd0 - rt_content) : rt_content;
    end

    // One iteration of shift-add multiply and of restoring divide.
    always_comb begin
        mul_sum   = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opnd} : 33'd0);
        mul_next  = {mul_sum, acc[31:1]};
        div_trial = {acc[63:32], acc[31]};
        div_ge    = (div_trial >= {1'b0, opnd});
        // When div_ge the true difference is below the divisor, so 32 bits hold it.
        div_rem   = div_trial[31:0] - opnd;
        div_next  = div_ge ? {div_rem, acc[30:0], 1'b1}
                           : {div_trial[31:0], acc[30:0], 1'b0};
    end

    // Sign correction applied in FIXUP.
    always_comb begin
        prod_fix = res_neg ? (64'd0 - acc) : acc;
        quot_fix = res_neg ? (32'd0 - acc[31:0]) : acc[31:0];
        rem_fix  = rem_neg ? (32'd0 - acc[63:32]) : acc[63:32];
    end

    // Control FSM, iteration datapath and HI/LO registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            count    <= 5'd0;
            acc      <= 64'd0;
            opnd     <= 32'd0;
            raw_rs   <= 32'd0;
            op_div   <= 1'b0;
            res_neg  <= 1'b0;
            rem_neg  <= 1'b0;
            div_zero <= 1'b0;
            hi_q     <= HILO_RESET;
            lo_q     <= HILO_RESET;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        case (functcode)
                            F_MTHI: hi_q <= rs_content;
                            F_MTLO: lo_q <= rs_content;
                            F_MULT, F_MULTU: begin
                                op_div   <= 1'b0;
                                opnd     <= mag_rs;
                                acc      <= {32'd0, mag_rt};
                                res_neg  <= is_signed && (rs_content[31] ^ rt_content[31]);
                                rem_neg  <= 1'b0;
                                div_zero <= 1'b0;
                                raw_rs   <= rs_content;
                                count    <= 5'd0;
                                state    <= RUN;
                            end
                            F_DIV, F_DIVU: begin
                                op_div   <= 1'b1;
                                opnd     <= mag_rt;
                                acc      <= {32'd0, mag_rs};
                                res_neg  <= is_signed && (rs_content[31] ^ rt_content[31]);
                                rem_neg  <= is_signed && rs_content[31];
                                div_zero <= (rt_content == 32'd0);
                                raw_rs   <= rs_content;
                                count    <= 5'd0;
                                state    <= RUN;
                            end
                            default: ;
                        endcase
                    end
                end
                RUN: begin
                    acc   <= op_div ? div_next : mul_next;
                    count <= count + 5'd1;
                    if (count == 5'd31)
                        state <= FIXUP;
                end
                FIXUP: begin
                    if (!op_div) begin
                        hi_q <= prod_fix[63:32];
                        lo_q <= prod_fix[31:0];
                    end else if (div_zero) begin
                        hi_q <= raw_rs;
                        lo_q <= 32'hFFFF_FFFF;
                    end else begin
                        hi_q <= rem_fix;
                        lo_q <= quot_fix;
                    end
                    done_q <= 1'b1;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy = (state != IDLE);
    assign done = done_q;
    assign HI   = hi_q;
    assign LO   = lo_q;

endmodule
